// File: rtl/level_pkg.sv
`default_nettype none
//==============================================================================
// Module : level_pkg
// Desc   : Shared types and sizing helpers for the level alarm monitor.
// Rev    : 1.0 - initial release
//==============================================================================
package level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam int C_PERSIST_DEF = 4;

  // Smallest digit count whose decimal range covers 2**width-1.
  function automatic int bcd_digits_for(input int width);
    longint unsigned max_val;
    longint unsigned span;
    int              digits;
    max_val = (64'd1 << width) - 64'd1;
    span    = 64'd10;
    digits  = 1;
    for (int i = 0; i < 19; i++) begin
      if (span <= max_val) begin
        digits = digits + 1;
        span   = span * 64'd10;
      end
    end
    return digits;
  endfunction

  // Persistence counter must be able to hold the value PERSIST.
  function automatic int persist_cnt_w(input int persist);
    return (persist < 1) ? 1 : $clog2(persist + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
//==============================================================================
// Module : bin2bcd_seq
// Desc   : Sequential shift-add-3 binary to packed BCD converter.
// Rev    : 1.0 - initial release
//==============================================================================
module bin2bcd_seq
  import level_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = bcd_digits_for(DATA_W)
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   din,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int SW     = 4 * DIGITS + DATA_W;
  localparam int ITER_W = $clog2(DATA_W + 1);
  localparam logic [ITER_W-1:0] C_LAST_ITER = ITER_W'(DATA_W - 1);

  conv_state_e         state_q, state_d;
  logic [SW-1:0]       shreg_q, shreg_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                done_q, done_d;
  logic [SW-1:0]       w_adj;

  // Digits sit above the binary field; the binary part passes through untouched.
  assign w_adj[DATA_W-1:0] = shreg_q[DATA_W-1:0];

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      logic [3:0] w_dig;
      assign w_dig = shreg_q[DATA_W + 4*g +: 4];
      assign w_adj[DATA_W + 4*g +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = {{(4*DIGITS){1'b0}}, din};
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shreg_d = w_adj << 1;
        iter_d  = iter_q + 1'b1;
        if (iter_q == C_LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = shreg_q[SW-1:DATA_W];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/level_alarm_monitor.sv
`default_nettype none
//==============================================================================
// Module : level_alarm_monitor
// Desc   : Level sample acceptance, BCD conversion and filtered high/low alarms.
// Rev    : 1.0 - initial release
//==============================================================================
module level_alarm_monitor
  import level_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DIGITS  = bcd_digits_for(DATA_W),
  parameter int HYST    = 2,
  parameter int PERSIST = C_PERSIST_DEF
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sensor_data,
  input  logic [DATA_W-1:0]   high_threshold,
  input  logic [DATA_W-1:0]   low_threshold,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                overrun,
  output logic                GOET,
  output logic                LOET,
  output logic                cfg_err
);

  localparam int XW    = DATA_W + 1;
  localparam int CNT_W = persist_cnt_w(PERSIST);
  localparam logic [XW-1:0]    C_HYST_X   = XW'(HYST);
  localparam logic [XW-1:0]    C_MAX_X    = {1'b0, {DATA_W{1'b1}}};
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PERSIST - 1);

  logic             w_busy;
  logic             w_accept;
  logic [XW-1:0]    w_data_x, w_high_x, w_low_x;
  logic [XW-1:0]    w_hi_clr_thr, w_lo_sum, w_lo_clr_thr;
  logic             w_hi_hit, w_lo_hit;

  logic             overrun_q, overrun_d;
  logic             goet_q, goet_d;
  logic             loet_q, loet_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;

  assign w_accept = sample_valid & ~w_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .start      (w_accept),
    .din        (sensor_data),
    .busy       (w_busy),
    .done       (bcd_valid),
    .bcd        (bcd)
  );

  assign cfg_err = (low_threshold >= high_threshold);

  // One extra bit keeps the hysteresis offsets free of wrap-around.
  assign w_data_x     = {1'b0, sensor_data};
  assign w_high_x     = {1'b0, high_threshold};
  assign w_low_x      = {1'b0, low_threshold};
  assign w_hi_clr_thr = (w_high_x >= C_HYST_X) ? (w_high_x - C_HYST_X) : '0;
  assign w_lo_sum     = w_low_x + C_HYST_X;
  assign w_lo_clr_thr = (w_lo_sum > C_MAX_X) ? C_MAX_X : w_lo_sum;

  // A hit is whatever would move the alarm toward its opposite state.
  assign w_hi_hit = goet_q ? (w_data_x < w_hi_clr_thr) : (w_data_x >= w_high_x);
  assign w_lo_hit = loet_q ? (w_data_x > w_lo_clr_thr) : (w_data_x <= w_low_x);

  always_comb begin
    overrun_d = sample_valid & w_busy;
    goet_d    = goet_q;
    loet_d    = loet_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    if (cfg_err) begin
      goet_d   = 1'b0;
      loet_d   = 1'b0;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end else if (w_accept) begin
      if (!w_hi_hit) begin
        hi_cnt_d = '0;
      end else if (hi_cnt_q >= C_CNT_LAST) begin
        goet_d   = ~goet_q;
        hi_cnt_d = '0;
      end else begin
        hi_cnt_d = hi_cnt_q + 1'b1;
      end

      if (!w_lo_hit) begin
        lo_cnt_d = '0;
      end else if (lo_cnt_q >= C_CNT_LAST) begin
        loet_d   = ~loet_q;
        lo_cnt_d = '0;
      end else begin
        lo_cnt_d = lo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      goet_q    <= 1'b0;
      loet_q    <= 1'b0;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
    end else begin
      overrun_q <= overrun_d;
      goet_q    <= goet_d;
      loet_q    <= loet_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
    end
  end

  assign busy    = w_busy;
  assign overrun = overrun_q;
  assign GOET    = goet_q & ~cfg_err;
  assign LOET    = loet_q & ~cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_level_alarm_monitor.sv
`default_nettype none
//==============================================================================
// Module : tb_level_alarm_monitor
// Desc   : Directed self-checking bench for level_alarm_monitor.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_level_alarm_monitor;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sensor_data;
  logic [7:0]  high_threshold;
  logic [7:0]  low_threshold;
  logic        busy;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        overrun;
  logic        GOET;
  logic        LOET;
  logic        cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  level_alarm_monitor #(
    .DATA_W  (8),
    .DIGITS  (3),
    .HYST    (2),
    .PERSIST (4)
  ) dut (
    .clk_100MHz     (clk_100MHz),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sensor_data    (sensor_data),
    .high_threshold (high_threshold),
    .low_threshold  (low_threshold),
    .busy           (busy),
    .bcd            (bcd),
    .bcd_valid      (bcd_valid),
    .overrun        (overrun),
    .GOET           (GOET),
    .LOET           (LOET),
    .cfg_err        (cfg_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One accepted sample followed by enough idle cycles to finish conversion.
  task automatic put(input logic [7:0] d);
    @(negedge clk_100MHz);
    sample_valid = 1'b1;
    sensor_data  = d;
    @(negedge clk_100MHz);
    sample_valid = 1'b0;
    repeat (9) @(negedge clk_100MHz);
  endtask

  task automatic put_n(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) put(d);
  endtask

  task automatic conv_check(input logic [7:0] d, input logic [11:0] exp);
    int          busy_n;
    int          val_n;
    logic        val_at9;
    logic [11:0] got_bcd;
    busy_n  = 0;
    val_n   = 0;
    val_at9 = 1'b0;
    got_bcd = '0;
    @(negedge clk_100MHz);
    sample_valid = 1'b1;
    sensor_data  = d;
    @(posedge clk_100MHz);
    #1;
    sample_valid = 1'b0;
    busy_n += int'(busy);
    val_n  += int'(bcd_valid);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk_100MHz);
      #1;
      busy_n += int'(busy);
      val_n  += int'(bcd_valid);
      if (e == 9) begin
        val_at9 = bcd_valid;
        got_bcd = bcd;
      end
    end
    check_eq($sformatf("busy_cycles_%0d", d), busy_n, 9);
    check_eq($sformatf("valid_pulses_%0d", d), val_n, 1);
    check_eq($sformatf("valid_at_edge9_%0d", d), val_at9, 1);
    check_eq($sformatf("bcd_%0d", d), got_bcd, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    sample_valid   = 1'b0;
    sensor_data    = '0;
    high_threshold = 8'd200;
    low_threshold  = 8'd50;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_bcd", bcd, 0);
    check_eq("rst_bcd_valid", bcd_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_goet", GOET, 0);
    check_eq("rst_loet", LOET, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;

    conv_check(8'd255, 12'h255);
    conv_check(8'd0,   12'h000);
    conv_check(8'd100, 12'h100);

    // High alarm: set after 4 hits, band holds, clear below 198.
    put_n(8'd200, 3);
    check_eq("goet_after_3x200", GOET, 0);
    put(8'd200);
    check_eq("goet_after_4x200", GOET, 1);
    put_n(8'd199, 4);
    check_eq("goet_band_199", GOET, 1);
    put_n(8'd197, 3);
    check_eq("goet_after_3x197", GOET, 1);
    put(8'd197);
    check_eq("goet_after_4x197", GOET, 0);

    // Low alarm: a non-hit restarts the persistence count.
    put(8'd50); put(8'd50); put(8'd60);
    put(8'd50); put(8'd50); put(8'd50);
    check_eq("loet_after_6", LOET, 0);
    put(8'd50);
    check_eq("loet_after_7", LOET, 1);
    put_n(8'd52, 4);
    check_eq("loet_band_52", LOET, 1);
    put_n(8'd53, 3);
    check_eq("loet_after_3x53", LOET, 1);
    put(8'd53);
    check_eq("loet_after_4x53", LOET, 0);
    put_n(8'd10, 4);
    check_eq("loet_after_4x10", LOET, 1);

    // Asynchronous reset in the middle of a conversion.
    check_eq("bcd_pre_reset", bcd, 12'h010);
    @(negedge clk_100MHz);
    sample_valid = 1'b1;
    sensor_data  = 8'd123;
    @(posedge clk_100MHz);
    #1;
    sample_valid = 1'b0;
    repeat (4) @(posedge clk_100MHz);
    #2;
    check_eq("busy_mid_conv", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_bcd", bcd, 0);
    check_eq("midrst_bcd_valid", bcd_valid, 0);
    check_eq("midrst_goet", GOET, 0);
    check_eq("midrst_loet", LOET, 0);
    check_eq("midrst_overrun", overrun, 0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    conv_check(8'd37, 12'h037);

    // sample_valid held high: accepts every 10 cycles, overrun in between.
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_100MHz);
      sample_valid = 1'b1;
      sensor_data  = 8'(11 + 7 * k);
      @(posedge clk_100MHz);
      #1;
      check_eq($sformatf("overrun_k%0d", k), overrun, (k % 10 != 0));
      check_eq($sformatf("bcd_valid_k%0d", k), bcd_valid, (k % 10 == 9));
      if (k % 10 == 9) begin
        check_eq($sformatf("stream_bcd_k%0d", k), bcd, to_bcd(11 + 7 * (k - 9)));
      end
    end
    @(negedge clk_100MHz);
    sample_valid = 1'b0;
    repeat (10) @(negedge clk_100MHz);

    // Threshold misconfiguration forces alarms off and holds counters.
    put_n(8'd255, 4);
    check_eq("goet_before_cfg", GOET, 1);
    @(negedge clk_100MHz);
    low_threshold  = 8'd150;
    high_threshold = 8'd100;
    #1;
    check_eq("cfg_err_set", cfg_err, 1);
    check_eq("cfg_goet_masked", GOET, 0);
    check_eq("cfg_loet_masked", LOET, 0);
    put_n(8'd255, 4);
    check_eq("cfg_goet_255", GOET, 0);
    put_n(8'd0, 4);
    check_eq("cfg_loet_0", LOET, 0);
    check_eq("cfg_err_hold", cfg_err, 1);
    @(negedge clk_100MHz);
    low_threshold = 8'd50;
    #1;
    check_eq("cfg_err_clear", cfg_err, 0);
    check_eq("goet_after_restore", GOET, 0);
    put_n(8'd255, 3);
    check_eq("goet_restore_3x255", GOET, 0);
    put(8'd255);
    check_eq("goet_restore_4x255", GOET, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
